// File: rtl/ctrl_pipe_unit.sv
// Purpose: MIPS32 ID-stage control decode carried through registered EX/MEM/WB stages.
// Latency: ID bundle on ex_* one edge later, mem_* after two, wb_* after three; stall is combinational.
// Backpressure: stall holds PC/IF-ID and injects an EX bubble; flush bubbles EX and MEM; WB always drains.
//
// Ports: clk/reset (async active-low); id_valid, opcode, id_rs, id_rt describe the ID instruction;
//        flush kills the ID and EX instructions; stall requests a load-use hold; illegal_op flags an
//        undecodable valid instruction in EX; ex_*/mem_*/wb_* are the per-stage control bundles;
//        bubble_cnt is a saturating count of stall and flush bubbles.
module ctrl_pipe_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int EXT_OPS    = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [5:0]            opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  flush,
  output logic                  stall,
  output logic                  illegal_op,
  output logic                  ex_valid,
  output logic [1:0]            ex_RegDst,
  output logic [1:0]            ex_ALUOp,
  output logic                  ex_ALUSrc,
  output logic                  ex_sign_or_zero,
  output logic                  ex_Jump,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  mem_valid,
  output logic                  mem_MemRead,
  output logic                  mem_MemWrite,
  output logic                  mem_Branch,
  output logic                  wb_valid,
  output logic                  wb_RegWrite,
  output logic [1:0]            wb_MemtoReg,
  output logic [CNT_W-1:0]      bubble_cnt
);

  // Controls grouped by the stage that consumes them, so each stage only stores what is still needed.
  typedef struct packed {
    logic [1:0] reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       sign_or_zero;
    logic       jump;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] mem_to_reg;
  } wb_ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  ex_ctrl_t              id_ex, ex_ctrl_q, ex_ctrl_d;
  mem_ctrl_t             id_mem, ex_mem_q, ex_mem_d, mem_ctrl_q, mem_ctrl_d;
  wb_ctrl_t              id_wb, ex_wb_q, ex_wb_d, mem_wb_q, mem_wb_d, wb_ctrl_q, wb_ctrl_d;
  logic                  id_illegal;
  logic                  ex_valid_q, ex_valid_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  illegal_q, illegal_d;
  logic [REG_ADDR_W-1:0] ex_rt_q, ex_rt_d;
  logic [CNT_W-1:0]      bubble_cnt_q, bubble_cnt_d;
  logic                  ex_load;

  // ID decode; unknown opcodes produce an all-zero (NOP) bundle tagged illegal.
  always_comb begin
    id_ex      = '0;
    id_mem     = '0;
    id_wb      = '0;
    id_illegal = 1'b0;
    case (opcode)
      OP_LW: begin
        id_ex.alu_src      = 1'b1;
        id_ex.sign_or_zero = 1'b1;
        id_mem.mem_read    = 1'b1;
        id_wb.reg_write    = 1'b1;
        id_wb.mem_to_reg   = 2'b01;
      end
      OP_SW: begin
        id_ex.alu_src      = 1'b1;
        id_ex.sign_or_zero = 1'b1;
        id_mem.mem_write   = 1'b1;
      end
      OP_BEQ: begin
        id_ex.alu_op       = 2'b01;
        id_ex.sign_or_zero = 1'b1;
        id_mem.branch      = 1'b1;
      end
      OP_RTYPE: begin
        id_ex.reg_dst   = 2'b01;
        id_ex.alu_op    = 2'b10;
        id_wb.reg_write = 1'b1;
      end
      OP_J: begin
        id_ex.jump = 1'b1;
      end
      OP_JAL: begin
        id_ex.jump       = 1'b1;
        id_ex.reg_dst    = 2'b10;
        id_wb.reg_write  = 1'b1;
        id_wb.mem_to_reg = 2'b10;
      end
      OP_ADDI: begin
        id_ex.alu_src      = 1'b1;
        id_ex.sign_or_zero = 1'b1;
        id_wb.reg_write    = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_SLTI: begin
        if (EXT_OPS != 0) begin
          id_ex.alu_src      = 1'b1;
          id_ex.alu_op       = 2'b11;
          // Logical immediates zero-extend; slti compares a signed immediate.
          id_ex.sign_or_zero = (opcode == OP_SLTI);
          id_wb.reg_write    = 1'b1;
        end else begin
          id_illegal = 1'b1;
        end
      end
      default: id_illegal = 1'b1;
    endcase
  end

  // Load-use hazard: the lw in EX has not produced its data yet; flush overrides because
  // the dependent ID instruction is being killed anyway.
  assign stall = id_valid & ex_valid_q & ex_mem_q.mem_read &
                 ((ex_rt_q == id_rs) | (ex_rt_q == id_rt)) & ~flush;

  assign ex_load = id_valid & ~stall & ~flush;

  always_comb begin
    // EX: take the ID bundle or a zeroed bubble (stall, flush or empty ID).
    ex_valid_d = ex_load;
    ex_ctrl_d  = ex_load ? id_ex  : '0;
    ex_mem_d   = ex_load ? id_mem : '0;
    ex_wb_d    = ex_load ? id_wb  : '0;
    ex_rt_d    = ex_load ? id_rt  : '0;
    illegal_d  = ex_load & id_illegal;

    // MEM: EX contents are already zero when invalid, so only flush needs masking.
    mem_valid_d = ex_valid_q & ~flush;
    mem_ctrl_d  = flush ? '0 : ex_mem_q;
    mem_wb_d    = flush ? '0 : ex_wb_q;

    // WB always drains MEM.
    wb_valid_d = mem_valid_q;
    wb_ctrl_d  = mem_wb_q;

    bubble_cnt_d = bubble_cnt_q;
    if ((stall | flush) && !(&bubble_cnt_q)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_mem_q     <= '0;
      ex_wb_q      <= '0;
      ex_rt_q      <= '0;
      illegal_q    <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_ctrl_q   <= '0;
      mem_wb_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_ctrl_q    <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_mem_q     <= ex_mem_d;
      ex_wb_q      <= ex_wb_d;
      ex_rt_q      <= ex_rt_d;
      illegal_q    <= illegal_d;
      mem_valid_q  <= mem_valid_d;
      mem_ctrl_q   <= mem_ctrl_d;
      mem_wb_q     <= mem_wb_d;
      wb_valid_q   <= wb_valid_d;
      wb_ctrl_q    <= wb_ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign illegal_op      = illegal_q;
  assign ex_valid        = ex_valid_q;
  assign ex_RegDst       = ex_ctrl_q.reg_dst;
  assign ex_ALUOp        = ex_ctrl_q.alu_op;
  assign ex_ALUSrc       = ex_ctrl_q.alu_src;
  assign ex_sign_or_zero = ex_ctrl_q.sign_or_zero;
  assign ex_Jump         = ex_ctrl_q.jump;
  assign ex_rt           = ex_rt_q;
  assign mem_valid       = mem_valid_q;
  assign mem_MemRead     = mem_ctrl_q.mem_read;
  assign mem_MemWrite    = mem_ctrl_q.mem_write;
  assign mem_Branch      = mem_ctrl_q.branch;
  assign wb_valid        = wb_valid_q;
  assign wb_RegWrite     = wb_ctrl_q.reg_write;
  assign wb_MemtoReg     = wb_ctrl_q.mem_to_reg;
  assign bubble_cnt      = bubble_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit. Three instances share stimulus: [0] defaults, [1] EXT_OPS=0, [2] CNT_W=4.
// The reference model tracks which instruction (opcode, rt) occupies each stage and derives the
// expected controls from the opcode table.
module tb_ctrl_pipe_unit;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [5:0] opcode;
  logic [4:0] id_rs, id_rt;
  logic       flush;

  logic       stall_o [3];
  logic       ill_o   [3];
  logic       exv_o   [3];
  logic [1:0] exrd_o  [3];
  logic [1:0] exop_o  [3];
  logic       exsrc_o [3];
  logic       exsgn_o [3];
  logic       exj_o   [3];
  logic [4:0] exrt_o  [3];
  logic       memv_o  [3];
  logic       mr_o    [3];
  logic       mw_o    [3];
  logic       br_o    [3];
  logic       wbv_o   [3];
  logic       rw_o    [3];
  logic [1:0] m2r_o   [3];
  logic [15:0] cnt_o  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int EXT = (g == 1) ? 0 : 1;
    localparam int CW  = (g == 2) ? 4 : 16;
    ctrl_pipe_unit #(.REG_ADDR_W(5), .EXT_OPS(EXT), .CNT_W(CW)) u_dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode),
      .id_rs(id_rs), .id_rt(id_rt), .flush(flush),
      .stall(stall_o[g]), .illegal_op(ill_o[g]),
      .ex_valid(exv_o[g]), .ex_RegDst(exrd_o[g]), .ex_ALUOp(exop_o[g]),
      .ex_ALUSrc(exsrc_o[g]), .ex_sign_or_zero(exsgn_o[g]), .ex_Jump(exj_o[g]),
      .ex_rt(exrt_o[g]),
      .mem_valid(memv_o[g]), .mem_MemRead(mr_o[g]), .mem_MemWrite(mw_o[g]), .mem_Branch(br_o[g]),
      .wb_valid(wbv_o[g]), .wb_RegWrite(rw_o[g]), .wb_MemtoReg(m2r_o[g]),
      .bubble_cnt(cnt_o[g][CW-1:0])
    );
  end

  int checks   = 0;
  int failures = 0;

  // Model: which instruction sits in each stage, plus total bubbles ever inserted.
  typedef struct packed {
    logic       v;
    logic [5:0] op;
    logic [4:0] rt;
  } rec_t;

  rec_t m_ex, m_mem, m_wb;
  int   raw_bubbles;
  logic mdl_stall;
  logic obs_stall [3];

  // Opcode table: {RegDst[2], ALUOp[2], ALUSrc, sign, Jump, MemRead, MemWrite, Branch,
  //                RegWrite, MemtoReg[2], illegal}
  function automatic logic [13:0] dec(input logic [5:0] op, input bit ext);
    case (op)
      OP_LW:   dec = 14'b00_00_1_1_0_1_0_0_1_01_0;
      OP_SW:   dec = 14'b00_00_1_1_0_0_1_0_0_00_0;
      OP_BEQ:  dec = 14'b00_01_0_1_0_0_0_1_0_00_0;
      OP_R:    dec = 14'b01_10_0_0_0_0_0_0_1_00_0;
      OP_J:    dec = 14'b00_00_0_0_1_0_0_0_0_00_0;
      OP_JAL:  dec = 14'b10_00_0_0_1_0_0_0_1_10_0;
      OP_ADDI: dec = 14'b00_00_1_1_0_0_0_0_1_00_0;
      OP_ANDI, OP_ORI: dec = ext ? 14'b00_11_1_0_0_0_0_0_1_00_0 : 14'd1;
      OP_SLTI: dec = ext ? 14'b00_11_1_1_0_0_0_0_1_00_0 : 14'd1;
      default: dec = 14'd1;
    endcase
  endfunction

  // Expected {stall, exv, ex[7], rt[5], ill, memv, mem[3], wbv, wb[3], cnt[16]} for instance k.
  function automatic logic [38:0] exp_vec(input int k);
    logic [13:0] de, dm, dw;
    int lim;
    logic [15:0] c;
    de  = m_ex.v  ? dec(m_ex.op,  k != 1) : 14'd0;
    dm  = m_mem.v ? dec(m_mem.op, k != 1) : 14'd0;
    dw  = m_wb.v  ? dec(m_wb.op,  k != 1) : 14'd0;
    lim = (k == 2) ? 15 : 65535;
    c   = 16'((raw_bubbles > lim) ? lim : raw_bubbles);
    exp_vec = {mdl_stall, m_ex.v, de[13:7], (m_ex.v ? m_ex.rt : 5'd0), de[0],
               m_mem.v, dm[6:4], m_wb.v, dw[3:1], c};
  endfunction

  function automatic logic [38:0] obs_vec(input int k);
    logic [15:0] c;
    c = (k == 2) ? {12'd0, cnt_o[2][3:0]} : cnt_o[k];
    obs_vec = {obs_stall[k], exv_o[k], exrd_o[k], exop_o[k], exsrc_o[k], exsgn_o[k], exj_o[k],
               (exv_o[k] ? exrt_o[k] : 5'd0), ill_o[k],
               memv_o[k], mr_o[k], mw_o[k], br_o[k], wbv_o[k], rw_o[k], m2r_o[k], c};
  endfunction

  // One clock: apply ID inputs at the falling edge, sample stall, advance model at the rising
  // edge, return at the next falling edge for output sampling.
  task automatic step(input bit v, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input bit fl);
    id_valid = v; opcode = op; id_rs = rs; id_rt = rt; flush = fl;
    #1;
    mdl_stall = v && m_ex.v && (m_ex.op == OP_LW) && (m_ex.rt == rs || m_ex.rt == rt) && !fl;
    for (int k = 0; k < 3; k++) obs_stall[k] = stall_o[k];
    @(posedge clk);
    m_wb  = m_mem;
    m_mem = fl ? '0 : m_ex;
    m_ex  = (v && !mdl_stall && !fl) ? {1'b1, op, rt} : '0;
    if (mdl_stall || fl) raw_bubbles++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    id_valid = 1'b0; opcode = '0; id_rs = '0; id_rt = '0; flush = 1'b0;
    reset = 1'b0;
    m_ex = '0; m_mem = '0; m_wb = '0; raw_bubbles = 0; mdl_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    step(1, OP_LW, 0, 3, 1);
    step(1, OP_ADDI, 0, 3, 0);
    reset = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({stall_o[k], exv_o[k], memv_o[k], wbv_o[k], ill_o[k], cnt_o[k][3:0]} !== 9'd0) begin
        failures++;
        $display("FAIL reset_state k=%0d got=%b exp=0", k,
                 {stall_o[k], exv_o[k], memv_o[k], wbv_o[k], ill_o[k], cnt_o[k][3:0]});
      end
    end
    do_reset();
  endtask

  task automatic test_decode_seq();
    logic [5:0] ops [7];
    logic [13:0] d;
    ops = '{OP_LW, OP_SW, OP_BEQ, OP_R, OP_J, OP_JAL, OP_ADDI};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1, ops[i], 5'd1, (i == 0) ? 5'd5 : 5'd2, 0);
      d = dec(ops[i], 1'b1);
      checks++;
      if ({exv_o[0], exrd_o[0], exop_o[0], exsrc_o[0], exsgn_o[0], exj_o[0], obs_stall[0]}
          !== {1'b1, d[13:7], 1'b0}) begin
        failures++;
        $display("FAIL ex_decode op=%b got=%b exp=%b", ops[i],
                 {exv_o[0], exrd_o[0], exop_o[0], exsrc_o[0], exsgn_o[0], exj_o[0], obs_stall[0]},
                 {1'b1, d[13:7], 1'b0});
      end
      if (i == 1) begin
        checks++;
        if ({memv_o[0], mr_o[0], mw_o[0], br_o[0]} !== 4'b1100) begin
          failures++;
          $display("FAIL lw_mem got=%b exp=1100", {memv_o[0], mr_o[0], mw_o[0], br_o[0]});
        end
      end
      if (i == 2) begin
        checks++;
        if ({wbv_o[0], rw_o[0], m2r_o[0]} !== 4'b1101) begin
          failures++;
          $display("FAIL lw_wb got=%b exp=1101", {wbv_o[0], rw_o[0], m2r_o[0]});
        end
      end
    end
  endtask

  task automatic test_load_use();
    do_reset();
    step(1, OP_LW, 5'd0, 5'd5, 0);
    step(1, OP_R, 5'd5, 5'd9, 0);
    checks++;
    if ({obs_stall[0], exv_o[0], memv_o[0], cnt_o[0]} !== {3'b101, 16'd1}) begin
      failures++;
      $display("FAIL load_use_stall got=%b/%0d exp=101/1",
               {obs_stall[0], exv_o[0], memv_o[0]}, cnt_o[0]);
    end
    step(1, OP_R, 5'd5, 5'd9, 0);
    checks++;
    if ({obs_stall[0], exv_o[0], exrd_o[0], exop_o[0], cnt_o[0]} !== {6'b010110, 16'd1}) begin
      failures++;
      $display("FAIL load_use_release got=%b/%0d exp=010110/1",
               {obs_stall[0], exv_o[0], exrd_o[0], exop_o[0]}, cnt_o[0]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    step(1, OP_LW, 5'd0, 5'd5, 0);
    step(1, OP_R, 5'd5, 5'd9, 1);
    checks++;
    if ({obs_stall[0], exv_o[0], memv_o[0], cnt_o[0]} !== {3'b000, 16'd1}) begin
      failures++;
      $display("FAIL flush_over_stall got=%b/%0d exp=000/1",
               {obs_stall[0], exv_o[0], memv_o[0]}, cnt_o[0]);
    end
  endtask

  task automatic test_ext_ops();
    do_reset();
    step(1, OP_ORI, 5'd0, 5'd1, 0);
    checks++;
    if ({exv_o[0], exop_o[0], exsrc_o[0], exsgn_o[0], ill_o[0]} !== 6'b111100) begin
      failures++;
      $display("FAIL ori_ext got=%b exp=111100",
               {exv_o[0], exop_o[0], exsrc_o[0], exsgn_o[0], ill_o[0]});
    end
    checks++;
    if ({exv_o[1], exrd_o[1], exop_o[1], exsrc_o[1], exsgn_o[1], exj_o[1], ill_o[1]} !== 9'b100000001) begin
      failures++;
      $display("FAIL ori_noext got=%b exp=100000001",
               {exv_o[1], exrd_o[1], exop_o[1], exsrc_o[1], exsgn_o[1], exj_o[1], ill_o[1]});
    end
    step(0, OP_R, 5'd0, 5'd0, 0);
    checks++;
    if ({exv_o[1], ill_o[1]} !== 2'b00) begin
      failures++;
      $display("FAIL illegal_clear got=%b exp=00", {exv_o[1], ill_o[1]});
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 1; i <= 34; i++) begin
      step(1, OP_LW, 5'd5, 5'd5, 0);
      if (i == 30 || i == 34) begin
        checks++;
        if (cnt_o[2][3:0] !== 4'd15 || cnt_o[0] !== 16'(i / 2)) begin
          failures++;
          $display("FAIL saturate step=%0d got=%0d/%0d exp=15/%0d", i, cnt_o[2][3:0], cnt_o[0], i / 2);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(0, OP_R, 5'd0, 5'd0, 1);
    step(1, OP_LW, 5'd0, 5'd5, 0);
    step(0, OP_R, 5'd0, 5'd0, 0);
    checks++;
    if ({memv_o[0], mr_o[0], cnt_o[0]} !== {2'b11, 16'd1}) begin
      failures++;
      $display("FAIL pre_async got=%b/%0d exp=11/1", {memv_o[0], mr_o[0]}, cnt_o[0]);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({exv_o[0], memv_o[0], mr_o[0], wbv_o[0], cnt_o[0]} !== 20'd0) begin
      failures++;
      $display("FAIL async_reset got=%b/%0d exp=0000/0",
               {exv_o[0], memv_o[0], mr_o[0], wbv_o[0]}, cnt_o[0]);
    end
    m_ex = '0; m_mem = '0; m_wb = '0; raw_bubbles = 0;
    @(negedge clk);
    reset = 1'b1;
    step(1, OP_ADDI, 5'd0, 5'd4, 0);
    checks++;
    if ({exv_o[0], exsrc_o[0], exsgn_o[0], exrt_o[0]} !== {3'b111, 5'd4}) begin
      failures++;
      $display("FAIL first_after_reset got=%b exp=11100100",
               {exv_o[0], exsrc_o[0], exsgn_o[0], exrt_o[0]});
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [12];
    bit v, fl;
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic [38:0] e, o;
    ops = '{OP_LW, OP_SW, OP_BEQ, OP_R, OP_J, OP_JAL, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI,
            6'b111111, 6'b010000};
    do_reset();
    v = 1'b0; op = '0; rs = '0; rt = '0;
    for (int n = 0; n < 400; n++) begin
      // A stalled instruction is held in ID and re-presented, as the PC/IF-ID hold would do.
      if (!mdl_stall) begin
        v  = ($urandom_range(0, 7) != 0);
        op = ($urandom_range(0, 2) == 0) ? OP_LW : ops[$urandom_range(0, 11)];
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
      end
      fl = ($urandom_range(0, 9) == 0);
      step(v, op, rs, rt, fl);
      for (int k = 0; k < 3; k++) begin
        e = exp_vec(k);
        o = obs_vec(k);
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL random n=%0d k=%0d got=%h exp=%h", n, k, o, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode_seq();
    test_load_use();
    test_flush();
    test_ext_ops();
    test_saturate();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
